mesh_term_agent: RTL and testbench

Parametrised, synthesizable traffic agent for one terminal of the `mesh_gnrtr` router mesh. It generates packet bursts toward any (row, col) destination and queues them in a TX FIFO exposed through the mesh's `pndng_i_in`/`data_out_i_in`/`popin` handshake. On the receive side it drains the mesh's `pndng`/`data_out`/`pop` port with a programmable pop back-pressure delay, checks each delivered packet's destination against its own ID, and keeps saturating statistics. One instance per mesh terminal (`2*ROWS + 2*COLUMS` instances) replaces behavioural drivers and monitors in emulation and long-run soak builds.

---
 rtl/mesh_pkg.sv | 44 ++++
 rtl/mesh_agent_fifo.sv | 54 +++++
 rtl/mesh_agent.sv | 172 +++++++++++++++++
 tb/tb_mesh_term_agent.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// Shared packet layout, FSM state types and helpers for the mesh terminal agent.
package mesh_pkg;

  localparam int NXT_W  = 8;
  localparam int ROW_W  = 4;
  localparam int COL_W  = 4;
  localparam int HDR_W  = NXT_W + ROW_W + COL_W + 1;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [0:0] {
    T_IDLE  = 1'b0,
    T_BURST = 1'b1
  } tx_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_POP  = 2'd2
  } rx_state_t;

  // Header bits that sit above the payload, MSB first.
  typedef struct packed {
    logic [NXT_W-1:0] nxt_jmp;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             mode;
  } pkt_fields_t;

  function automatic pkt_fields_t build_hdr(input logic [ROW_W-1:0] row,
                                            input logic [COL_W-1:0] col,
                                            input logic             mode);
    pkt_fields_t h;
    h.nxt_jmp = '0;
    h.row     = row;
    h.col     = col;
    h.mode    = mode;
    return h;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mesh_agent_fifo.sv
// Synchronous FIFO of any depth >= 2; a pop lets a push land in the same cycle even when full.
module mesh_agent_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mesh_agent.sv
// Mesh terminal traffic agent: burst generator into a TX FIFO plus a delayed-pop RX checker.
// Optional MESH_AGENT_LATENCY_EN stamps packets with a cycle counter and reports latency.
module mesh_term_agent
  import mesh_pkg::*;
#(
  parameter int PCKG_SZ    = 40,
  parameter int FIFO_DEPTH = 10,
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4,
  parameter int ROW_ID     = 0,
  parameter int COL_ID     = 0,
  parameter logic [PCKG_SZ-19:0] BDCST = {PCKG_SZ-18{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_row,
  input  logic [3:0]         cmd_col,
  input  logic               cmd_mode,
  input  logic [PCKG_SZ-18:0] cmd_payload,
  input  logic [7:0]         cmd_len,
  input  logic [3:0]         pop_delay,
  output logic               pndng_i_in,
  output logic [PCKG_SZ-1:0] data_out_i_in,
  input  logic               popin,
  input  logic               pndng,
  input  logic [PCKG_SZ-1:0] data_out,
  output logic               pop,
  output logic [15:0]        tx_cnt,
  output logic [15:0]        rx_cnt,
  output logic [15:0]        err_cnt,
  output logic               err,
`ifdef MESH_AGENT_LATENCY_EN
  output logic [15:0]        lat_max,
  output logic [31:0]        lat_sum,
`endif
  output logic [0:0]         dbg_tx_state,
  output logic [1:0]         dbg_rx_state
);

  localparam int PW = PCKG_SZ - 17;
  localparam logic [3:0] MY_ROW = 4'(ROW_ID);
  localparam logic [3:0] MY_COL = 4'(COL_ID);

  // Handshakes: a command transfers on a rising edge with cmd_valid && cmd_ready; the mesh
  // takes the TX head on popin while pndng_i_in is high, and the agent takes the RX packet on pop.
  tx_state_t          tx_state;
  rx_state_t          rx_state;
  logic [7:0]         rem;
  logic [3:0]         row_q, col_q;
  logic               mode_q;
  logic [PW-1:0]      pay_q, push_pay;
  logic [PCKG_SZ-1:0] push_pkt;
  logic               tx_push, tx_pop, fifo_full, fifo_empty;
  logic [3:0]         wait_cnt;
  logic               rx_hit, bcast;
  logic               rx_unused;

  assign dbg_tx_state = tx_state;
  assign dbg_rx_state = rx_state;
  assign cmd_ready    = (tx_state == T_IDLE);
  assign pndng_i_in   = !fifo_empty;
  assign tx_pop       = popin && !fifo_empty;
  assign tx_push      = (tx_state == T_BURST) && (!fifo_full || tx_pop);
  assign push_pkt     = {build_hdr(row_q, col_q, mode_q), push_pay};
  assign pop          = (rx_state == R_POP);

`ifdef MESH_AGENT_LATENCY_EN
  logic [15:0] now, lat;
  logic [32:0] sum_ext;
  assign push_pay  = {pay_q[PW-1:16], now};
  assign bcast     = (data_out[PCKG_SZ-19:16] == BDCST[PCKG_SZ-19:16]);
  assign lat       = now - data_out[15:0];
  assign sum_ext   = {1'b0, lat_sum} + {17'd0, lat};
  assign rx_unused = ^{data_out[PCKG_SZ-1 -: 8], data_out[PCKG_SZ-17], data_out[PCKG_SZ-18]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      now     <= '0;
      lat_max <= '0;
      lat_sum <= '0;
    end else begin
      now <= now + 16'd1;
      if (rx_state == R_POP) begin
        if (lat > lat_max) lat_max <= lat;
        lat_sum <= sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
      end
    end
  end
`else
  assign push_pay  = pay_q;
  assign bcast     = (data_out[PCKG_SZ-19:0] == BDCST);
  assign rx_unused = ^{data_out[PCKG_SZ-1 -: 8], data_out[PCKG_SZ-17], data_out[PCKG_SZ-18]};
`endif

  assign rx_hit = ((data_out[PCKG_SZ-9 -: 4] == MY_ROW) && (data_out[PCKG_SZ-13 -: 4] == MY_COL))
                  || bcast;

  mesh_agent_fifo #(.W(PCKG_SZ), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .din   (push_pkt),
    .pop   (tx_pop),
    .dout  (data_out_i_in),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= T_IDLE;
      rem      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      mode_q   <= 1'b0;
      pay_q    <= '0;
      tx_cnt   <= '0;
    end else begin
      if (tx_pop) tx_cnt <= sat_inc16(tx_cnt);
      case (tx_state)
        T_IDLE: if (cmd_valid) begin
          row_q    <= cmd_row;
          col_q    <= cmd_col;
          mode_q   <= cmd_mode;
          pay_q    <= cmd_payload;
          rem      <= (cmd_len == 8'd0) ? 8'd1 : cmd_len;
          tx_state <= T_BURST;
        end
        T_BURST: if (tx_push) begin
          pay_q <= pay_q + PW'(1);
          rem   <= rem - 8'd1;
          if (rem == 8'd1) tx_state <= T_IDLE;
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= R_IDLE;
      wait_cnt <= '0;
      rx_cnt   <= '0;
      err_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      case (rx_state)
        R_IDLE: if (pndng) begin
          wait_cnt <= pop_delay;
          rx_state <= R_WAIT;
        end
        // The pop is committed once waiting starts, even if pndng drops meanwhile.
        R_WAIT: begin
          if (wait_cnt == 4'd0) rx_state <= R_POP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        R_POP: begin
          rx_state <= R_IDLE;
          rx_cnt   <= sat_inc16(rx_cnt);
          if (!rx_hit) begin
            err_cnt <= sat_inc16(err_cnt);
            err     <= 1'b1;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_term_agent.sv
// Self-checking bench for mesh_term_agent: TX scoreboard of expected FIFO heads, RX timing/check counters.
module tb_mesh_term_agent;

  localparam int PCKG_SZ = 40;
  localparam int PW      = PCKG_SZ - 17;
  localparam int DEPTH   = 10;

  logic               clk = 1'b0;
  logic               reset;
  logic               cmd_valid, cmd_ready, cmd_mode;
  logic [3:0]         cmd_row, cmd_col, pop_delay;
  logic [PW-1:0]      cmd_payload;
  logic [7:0]         cmd_len;
  logic               pndng_i_in, popin, pndng, pop, err;
  logic [PCKG_SZ-1:0] data_out_i_in, data_out;
  logic [15:0]        tx_cnt, rx_cnt, err_cnt;
  logic [0:0]         dbg_tx_state;
  logic [1:0]         dbg_rx_state;
`ifdef MESH_AGENT_LATENCY_EN
  logic [15:0]        lat_max;
  logic [31:0]        lat_sum;
`endif

  logic [PCKG_SZ-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int exp_tx = 0;
  int exp_rx = 0;
  int exp_errs = 0;

  mesh_term_agent #(
    .PCKG_SZ(PCKG_SZ), .FIFO_DEPTH(DEPTH), .ROWS(4), .COLUMS(4), .ROW_ID(1), .COL_ID(0)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_mode(cmd_mode), .cmd_payload(cmd_payload), .cmd_len(cmd_len), .pop_delay(pop_delay),
    .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in), .popin(popin),
    .pndng(pndng), .data_out(data_out), .pop(pop),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .err_cnt(err_cnt), .err(err),
`ifdef MESH_AGENT_LATENCY_EN
    .lat_max(lat_max), .lat_sum(lat_sum),
`endif
    .dbg_tx_state(dbg_tx_state), .dbg_rx_state(dbg_rx_state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PCKG_SZ-1:0] mk_pkt(input logic [3:0] r, input logic [3:0] c,
                                                 input logic m, input logic [PW-1:0] p);
    return {8'h00, r, c, m, p};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_cmd(input logic [3:0] r, input logic [3:0] c, input logic m,
                          input logic [PW-1:0] p, input logic [7:0] len);
    int n;
    logic [PW-1:0] pay;
    cmd_row = r; cmd_col = c; cmd_mode = m; cmd_payload = p; cmd_len = len;
    cmd_valid = 1'b1;
    check("cmd_ready_pre", cmd_ready, 1);
    n = (len == 0) ? 1 : int'(len);
    pay = p;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mk_pkt(r, c, m, pay));
      pay = pay + PW'(1);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain_one(input string tag);
    int t = 0;
    logic [PCKG_SZ-1:0] e;
    while (!pndng_i_in && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!pndng_i_in) check({tag, "_timeout"}, 0, 1);
    else if (exp_q.size() == 0) check({tag, "_unexpected"}, data_out_i_in, 0);
    else begin
      e = exp_q.pop_front();
      check(tag, data_out_i_in, e);
      popin = 1'b1;
      @(negedge clk);
      popin = 1'b0;
      exp_tx++;
    end
  endtask

  task automatic rx_packet(input string tag, input logic [PCKG_SZ-1:0] pkt,
                           input logic [3:0] dly, input bit bad);
    int t = 0;
    pop_delay = dly;
    data_out  = pkt;
    pndng     = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!pop && t < 40);
    check({tag, "_lat"}, t, int'(dly) + 2);
    @(negedge clk);
    pndng = 1'b0;
    data_out = '0;
    check({tag, "_pulse"}, pop, 0);
    exp_rx++;
    if (bad) exp_errs++;
    check({tag, "_rx_cnt"}, rx_cnt, exp_rx);
    check({tag, "_err_cnt"}, err_cnt, exp_errs);
    check({tag, "_err"}, err, exp_errs != 0);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 0; cmd_row = 0; cmd_col = 0; cmd_mode = 0; cmd_payload = 0;
    cmd_len = 0; pop_delay = 0; popin = 0; pndng = 0; data_out = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_pndng_i_in", pndng_i_in, 0);
    check("rst_data", data_out_i_in, 0);
    check("rst_pop", pop, 0);
    check("rst_counters", {tx_cnt, rx_cnt, err_cnt}, 0);
    check("rst_err", err, 0);
    reset = 1'b1;
    @(negedge clk);

    // single packet and TX latency
    send_cmd(4'd2, 4'd3, 1'b1, 23'd5, 8'd1);
    check("tx_lat_n", pndng_i_in, 0);
    @(negedge clk);
    check("tx_lat_n1", pndng_i_in, 1);
    check("single_lit", data_out_i_in, {8'h00, 4'h2, 4'h3, 1'b1, 23'd5});
    drain_one("single_head");
    check("single_tx_cnt", tx_cnt, exp_tx);
    check("single_empty", pndng_i_in, 0);

    // FIFO fills, burst stalls, then resumes as the mesh pops
    send_cmd(4'd3, 4'd1, 1'b0, 23'd100, 8'd12);
    repeat (12) @(negedge clk);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_pndng", pndng_i_in, 1);
    drain_one("full_head0");
    drain_one("full_head1");
    repeat (4) @(negedge clk);
    check("full_resume_ready", cmd_ready, 1);
    for (int i = 2; i < 12; i++) drain_one($sformatf("full_head%0d", i));
    check("full_tx_cnt", tx_cnt, exp_tx);

    // payload wrap and len 0 treated as 1
    send_cmd(4'd0, 4'd1, 1'b0, {PW{1'b1}}, 8'd2);
    drain_one("wrap_first");
    check("wrap_lit", data_out_i_in, {8'h00, 4'h0, 4'h1, 1'b0, 23'd0});
    drain_one("wrap_second");
    send_cmd(4'd1, 4'd1, 1'b1, 23'd77, 8'd0);
    drain_one("len0_head");
    repeat (3) @(negedge clk);
    check("len0_empty", pndng_i_in, 0);

    for (int k = 0; k < 4; k++) begin
      send_cmd(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               PW'($urandom), 8'($urandom_range(1, 4)));
      while (exp_q.size() > 0) drain_one($sformatf("rand%0d", k));
    end
    check("rand_tx_cnt", tx_cnt, exp_tx);

    // RX: match with delay, mismatch, broadcast, zero delay
    rx_packet("rx_match", mk_pkt(4'd1, 4'd0, 1'b0, 23'd9), 4'd4, 1'b0);
    rx_packet("rx_miss", mk_pkt(4'd2, 4'd2, 1'b0, 23'd7), 4'd0, 1'b1);
    rx_packet("rx_bcast", mk_pkt(4'd2, 4'd2, 1'b1, {1'b0, {PW-1{1'b1}}}), 4'd2, 1'b0);
    rx_packet("rx_bcast_msb", mk_pkt(4'd3, 4'd3, 1'b0, {PW{1'b1}}), 4'd1, 1'b0);
    rx_packet("rx_miss_near", mk_pkt(4'd3, 4'd3, 1'b0, {1'b1, 1'b0, {PW-2{1'b1}}}), 4'd3, 1'b1);

    // asynchronous reset mid-burst
    send_cmd(4'd3, 4'd3, 1'b0, 23'd9, 8'd10);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_pndng_i_in", pndng_i_in, 0);
    check("arst_counters", {tx_cnt, rx_cnt, err_cnt}, 0);
    check("arst_err", err, 0);
    check("arst_states", {dbg_tx_state, dbg_rx_state}, 0);
    exp_q.delete();
    exp_tx = 0; exp_rx = 0; exp_errs = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_cmd(4'd1, 4'd2, 1'b0, 23'd33, 8'd1);
    drain_one("post_rst_head");
    check("post_rst_tx_cnt", tx_cnt, exp_tx);
    check("post_rst_empty", pndng_i_in, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
